// File: rtl/cphase_gate_pipelined.sv
// Controlled-phase rotation stage R_k for the QFT datapath.
// Four-stage valid/ready pipeline. When the control qubit is set, beta is
// rotated by e^(i*pi/2^k); otherwise beta is passed through bit-exact.
// Alpha and the tag travel alongside the data unchanged. The whole pipe
// stalls as a unit whenever the output register is full and not drained.
module cphase_gate_pipelined #(
  parameter  int K_WIDTH     = 3,
  parameter  int TAG_WIDTH   = 4,
  localparam int TOTAL_WIDTH = 8,
  localparam int FRAC_WIDTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_s,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_ctrl,
  input  logic [K_WIDTH-1:0]            in_k,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  input  logic signed [TOTAL_WIDTH-1:0] alpha_r,
  input  logic signed [TOTAL_WIDTH-1:0] alpha_i,
  input  logic signed [TOTAL_WIDTH-1:0] beta_r,
  input  logic signed [TOTAL_WIDTH-1:0] beta_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic signed [TOTAL_WIDTH-1:0] new_alpha_r,
  output logic signed [TOTAL_WIDTH-1:0] new_alpha_i,
  output logic signed [TOTAL_WIDTH-1:0] new_beta_r,
  output logic signed [TOTAL_WIDTH-1:0] new_beta_i
);

  localparam int PW = 2 * TOTAL_WIDTH;
  localparam int SW = 2 * TOTAL_WIDTH + 1;

  logic adv;

  // Stage 1: registered inputs plus the (cos, sin) pair for this k
  logic                          s1Valid_q, s1Ctrl_q;
  logic [TAG_WIDTH-1:0]          s1Tag_q;
  logic signed [TOTAL_WIDTH-1:0] s1AlphaR_q, s1AlphaI_q, s1BetaR_q, s1BetaI_q;
  logic signed [TOTAL_WIDTH-1:0] s1C_q, s1S_q, romC_d, romS_d;

  // Stage 2: the four partial products
  logic                          s2Valid_q, s2Ctrl_q;
  logic [TAG_WIDTH-1:0]          s2Tag_q;
  logic signed [TOTAL_WIDTH-1:0] s2AlphaR_q, s2AlphaI_q, s2BetaR_q, s2BetaI_q;
  logic signed [PW-1:0]          pBrC_q, pBiS_q, pBrS_q, pBiC_q;
  logic signed [PW-1:0]          pBrC_d, pBiS_d, pBrS_d, pBiC_d;

  // Stage 3: full-precision rotated real and imaginary parts
  logic                          s3Valid_q, s3Ctrl_q;
  logic [TAG_WIDTH-1:0]          s3Tag_q;
  logic signed [TOTAL_WIDTH-1:0] s3AlphaR_q, s3AlphaI_q, s3BetaR_q, s3BetaI_q;
  logic signed [SW-1:0]          s3Re_q, s3Im_q, s3Re_d, s3Im_d;

  // Stage 4: output register
  logic                          outValid_q;
  logic [TAG_WIDTH-1:0]          outTag_q;
  logic signed [TOTAL_WIDTH-1:0] outAlphaR_q, outAlphaI_q, outBetaR_q, outBetaI_q;
  logic signed [TOTAL_WIDTH-1:0] outBetaR_d, outBetaI_d;

  // The pipe moves only when the output slot is empty or being drained
  always_comb begin
    adv      = !outValid_q || out_ready;
    in_ready = adv;
  end

  // Phase ROM: S3.4 cos/sin of pi/2^k; k=0 is a pure sign flip
  always_comb begin
    romC_d = 8'sd16;
    romS_d = 8'sd0;
    case (int'(in_k))
      0: begin romC_d = -8'sd16; romS_d = 8'sd0;  end
      1: begin romC_d = 8'sd0;   romS_d = 8'sd16; end
      2: begin romC_d = 8'sd11;  romS_d = 8'sd11; end
      3: begin romC_d = 8'sd15;  romS_d = 8'sd6;  end
      4: begin romC_d = 8'sd16;  romS_d = 8'sd3;  end
      5: begin romC_d = 8'sd16;  romS_d = 8'sd2;  end
      6: begin romC_d = 8'sd16;  romS_d = 8'sd1;  end
      default: begin romC_d = 8'sd16; romS_d = 8'sd0; end
    endcase
  end

  // Datapath arithmetic between stages; output takes bits [11:4] which is
  // an arithmetic shift right by the fraction width followed by wrapping truncation
  always_comb begin
    pBrC_d     = s1BetaR_q * s1C_q;
    pBiS_d     = s1BetaI_q * s1S_q;
    pBrS_d     = s1BetaR_q * s1S_q;
    pBiC_d     = s1BetaI_q * s1C_q;
    s3Re_d     = {pBrC_q[PW-1], pBrC_q} - {pBiS_q[PW-1], pBiS_q};
    s3Im_d     = {pBrS_q[PW-1], pBrS_q} + {pBiC_q[PW-1], pBiC_q};
    outBetaR_d = s3Ctrl_q ? TOTAL_WIDTH'(s3Re_q >>> FRAC_WIDTH) : s3BetaR_q;
    outBetaI_d = s3Ctrl_q ? TOTAL_WIDTH'(s3Im_q >>> FRAC_WIDTH) : s3BetaI_q;
  end

  // Stage 1 register: capture the input pair and its ROM constants
  always_ff @(posedge clk) begin
    if (rst_s) begin
      s1Valid_q <= 1'b0; s1Ctrl_q <= 1'b0; s1Tag_q <= '0;
      s1AlphaR_q <= '0; s1AlphaI_q <= '0; s1BetaR_q <= '0; s1BetaI_q <= '0;
      s1C_q <= '0; s1S_q <= '0;
    end else if (adv) begin
      s1Valid_q <= in_valid; s1Ctrl_q <= in_ctrl; s1Tag_q <= in_tag;
      s1AlphaR_q <= alpha_r; s1AlphaI_q <= alpha_i;
      s1BetaR_q <= beta_r; s1BetaI_q <= beta_i;
      s1C_q <= romC_d; s1S_q <= romS_d;
    end
  end

  // Stage 2 register: partial products plus the bypass copy of beta
  always_ff @(posedge clk) begin
    if (rst_s) begin
      s2Valid_q <= 1'b0; s2Ctrl_q <= 1'b0; s2Tag_q <= '0;
      s2AlphaR_q <= '0; s2AlphaI_q <= '0; s2BetaR_q <= '0; s2BetaI_q <= '0;
      pBrC_q <= '0; pBiS_q <= '0; pBrS_q <= '0; pBiC_q <= '0;
    end else if (adv) begin
      s2Valid_q <= s1Valid_q; s2Ctrl_q <= s1Ctrl_q; s2Tag_q <= s1Tag_q;
      s2AlphaR_q <= s1AlphaR_q; s2AlphaI_q <= s1AlphaI_q;
      s2BetaR_q <= s1BetaR_q; s2BetaI_q <= s1BetaI_q;
      pBrC_q <= pBrC_d; pBiS_q <= pBiS_d; pBrS_q <= pBrS_d; pBiC_q <= pBiC_d;
    end
  end

  // Stage 3 register: combined real and imaginary sums
  always_ff @(posedge clk) begin
    if (rst_s) begin
      s3Valid_q <= 1'b0; s3Ctrl_q <= 1'b0; s3Tag_q <= '0;
      s3AlphaR_q <= '0; s3AlphaI_q <= '0; s3BetaR_q <= '0; s3BetaI_q <= '0;
      s3Re_q <= '0; s3Im_q <= '0;
    end else if (adv) begin
      s3Valid_q <= s2Valid_q; s3Ctrl_q <= s2Ctrl_q; s3Tag_q <= s2Tag_q;
      s3AlphaR_q <= s2AlphaR_q; s3AlphaI_q <= s2AlphaI_q;
      s3BetaR_q <= s2BetaR_q; s3BetaI_q <= s2BetaI_q;
      s3Re_q <= s3Re_d; s3Im_q <= s3Im_d;
    end
  end

  // Stage 4 register: select rotated or bypassed beta and present the result
  always_ff @(posedge clk) begin
    if (rst_s) begin
      outValid_q <= 1'b0; outTag_q <= '0;
      outAlphaR_q <= '0; outAlphaI_q <= '0; outBetaR_q <= '0; outBetaI_q <= '0;
    end else if (adv) begin
      outValid_q <= s3Valid_q; outTag_q <= s3Tag_q;
      outAlphaR_q <= s3AlphaR_q; outAlphaI_q <= s3AlphaI_q;
      outBetaR_q <= outBetaR_d; outBetaI_q <= outBetaI_d;
    end
  end

  assign out_valid   = outValid_q;
  assign out_tag     = outTag_q;
  assign new_alpha_r = outAlphaR_q;
  assign new_alpha_i = outAlphaI_q;
  assign new_beta_r  = outBetaR_q;
  assign new_beta_i  = outBetaI_q;

endmodule

// File: tb/tb_cphase_gate_pipelined.sv
// Directed testbench for cphase_gate_pipelined: single-pair rotations,
// streaming, backpressure and mid-stream reset, all with hand-computed values.
module tb_cphase_gate_pipelined;

  logic              clk = 1'b0;
  logic              rst_s = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_ctrl = 1'b0;
  logic [2:0]        in_k = '0;
  logic [3:0]        in_tag = '0;
  logic signed [7:0] alpha_r = '0, alpha_i = '0, beta_r = '0, beta_i = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [3:0]        out_tag;
  logic signed [7:0] new_alpha_r, new_alpha_i, new_beta_r, new_beta_i;

  int passCount  = 0;
  int checkCount = 0;

  cphase_gate_pipelined #(.K_WIDTH(3), .TAG_WIDTH(4)) dut (
    .clk(clk), .rst_s(rst_s),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_k(in_k), .in_tag(in_tag),
    .alpha_r(alpha_r), .alpha_i(alpha_i), .beta_r(beta_r), .beta_i(beta_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .new_alpha_r(new_alpha_r), .new_alpha_i(new_alpha_i),
    .new_beta_r(new_beta_r), .new_beta_i(new_beta_i)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Power-on reset: everything must read zero once reset has been sampled
  task automatic test_reset();
    rst_s = 1'b1;
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%0b want=0", out_valid);
    else passCount++;
    checkCount++;
    if ({new_beta_r, new_beta_i, new_alpha_r, new_alpha_i, out_tag} !== 36'd0)
      $display("[TB] FAIL reset_outputs got=%h want=0", {new_beta_r, new_beta_i, new_alpha_r, new_alpha_i, out_tag});
    else passCount++;
    checkCount++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got=%0b want=1", in_ready);
    else passCount++;
  endtask

  // Single pairs through an empty pipe: value, alpha/tag passthrough and latency
  task automatic test_rotation();
    int vCtrl[9] = '{1, 1, 1, 0, 1, 1, 1, 1, 1};
    int vK[9]    = '{2, 1, 3, 0, 0, 7, 2, 1, 0};
    int vAr[9]   = '{5, 0, 0, 7, 0, -1, 3, -9, 1};
    int vAi[9]   = '{-3, 0, 0, 1, 0, 2, -4, 8, -1};
    int vBr[9]   = '{16, 16, -16, -128, -128, 20, -7, 127, -128};
    int vBi[9]   = '{0, 0, 0, 127, 0, -8, 3, 127, -128};
    int vTag[9]  = '{9, 1, 2, 3, 4, 5, 6, 7, 8};
    int eBr[9]   = '{11, 0, -15, -128, -128, 20, -7, -127, -128};
    int eBi[9]   = '{11, 16, -6, 127, 0, -8, -3, 127, -128};
    int lat;
    logic signed [7:0] expBr, expBi, expAr, expAi;
    logic [3:0] expTag;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_ctrl = vCtrl[i][0]; in_k = vK[i][2:0]; in_tag = vTag[i][3:0];
      alpha_r = vAr[i][7:0]; alpha_i = vAi[i][7:0]; beta_r = vBr[i][7:0]; beta_i = vBi[i][7:0];
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      expBr = eBr[i][7:0]; expBi = eBi[i][7:0];
      expAr = vAr[i][7:0]; expAi = vAi[i][7:0]; expTag = vTag[i][3:0];
      checkCount++;
      if (lat !== 4) $display("[TB] FAIL rot%0d_latency got=%0d want=4", i, lat);
      else passCount++;
      checkCount++;
      if (new_beta_r !== expBr || new_beta_i !== expBi)
        $display("[TB] FAIL rot%0d_beta got=(%0d,%0d) want=(%0d,%0d)", i, new_beta_r, new_beta_i, expBr, expBi);
      else passCount++;
      checkCount++;
      if (new_alpha_r !== expAr || new_alpha_i !== expAi || out_tag !== expTag)
        $display("[TB] FAIL rot%0d_alpha_tag got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", i,
                 new_alpha_r, new_alpha_i, out_tag, expAr, expAi, expTag);
      else passCount++;
    end
  endtask

  // Eight pairs on consecutive cycles with free output: one result per cycle, in order
  task automatic test_back_to_back();
    int eBr[8] = '{16, 0, 16, 15, 16, 16, 16, 16};
    int eBi[8] = '{0, 16, 0, 6, 0, 2, 0, 0};
    logic expV;
    logic signed [7:0] expBr, expBi, expAr;
    logic [3:0] expTag;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      expV = (cyc >= 4 && cyc < 12);
      checkCount++;
      if (out_valid !== expV) $display("[TB] FAIL b2b_valid_c%0d got=%0b want=%0b", cyc, out_valid, expV);
      else passCount++;
      if (expV && out_valid === 1'b1) begin
        expTag = 4'(cyc - 4); expBr = eBr[cyc-4][7:0]; expBi = eBi[cyc-4][7:0]; expAr = 8'(cyc - 4);
        checkCount++;
        if (out_tag !== expTag || new_beta_r !== expBr || new_beta_i !== expBi || new_alpha_r !== expAr)
          $display("[TB] FAIL b2b_data_c%0d got=(t%0d,%0d,%0d,a%0d) want=(t%0d,%0d,%0d,a%0d)", cyc,
                   out_tag, new_beta_r, new_beta_i, new_alpha_r, expTag, expBr, expBi, expAr);
        else passCount++;
      end
      if (cyc < 8) begin
        in_valid = 1'b1; in_ctrl = cyc[0]; in_k = cyc[2:0]; in_tag = cyc[3:0];
        alpha_r = 8'(cyc); alpha_i = 8'(-cyc); beta_r = 8'sd16; beta_i = 8'sd0;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  // Output blocked: pipe fills with four pairs then stalls; release drains all six
  task automatic test_backpressure();
    int p = 0;
    int got = 0;
    int extras = 0;
    logic [3:0] expTag;
    logic signed [7:0] expBr;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (p < 6) begin
        in_valid = 1'b1; in_ctrl = 1'b0; in_k = 3'd0; in_tag = 4'(10 + p);
        alpha_r = 8'(p); alpha_i = 8'(p); beta_r = 8'(10 + p); beta_i = 8'(-(10 + p));
      end else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) p++;
    end
    checkCount++;
    if (p !== 4) $display("[TB] FAIL bp_accepted got=%0d want=4", p);
    else passCount++;
    checkCount++;
    if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready got=%0b want=0", in_ready);
    else passCount++;
    checkCount++;
    if (out_valid !== 1'b1 || out_tag !== 4'd10 || new_beta_r !== 8'sd10 || new_beta_i !== -8'sd10)
      $display("[TB] FAIL bp_hold got=(v%0b,t%0d,%0d,%0d) want=(v1,t10,10,-10)", out_valid, out_tag, new_beta_r, new_beta_i);
    else passCount++;

    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid === 1'b1) begin
        if (got >= 6) extras++;
        else begin
          expTag = 4'(10 + got); expBr = 8'(10 + got);
          checkCount++;
          if (out_tag !== expTag || new_beta_r !== expBr)
            $display("[TB] FAIL bp_drain%0d got=(t%0d,%0d) want=(t%0d,%0d)", got, out_tag, new_beta_r, expTag, expBr);
          else passCount++;
          got++;
        end
      end
      if (p < 6) begin
        in_valid = 1'b1; in_ctrl = 1'b0; in_k = 3'd0; in_tag = 4'(10 + p);
        alpha_r = 8'(p); alpha_i = 8'(p); beta_r = 8'(10 + p); beta_i = 8'(-(10 + p));
      end else in_valid = 1'b0;
      #1;
      if (in_valid && in_ready) p++;
      @(negedge clk);
    end
    checkCount++;
    if (got !== 6 || extras !== 0) $display("[TB] FAIL bp_count got=%0d extra=%0d want=6 extra=0", got, extras);
    else passCount++;
  endtask

  // Reset with pairs in flight: outputs clear immediately and nothing stale emerges
  task automatic test_reset_midstream();
    int stale = 0;
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_ctrl = 1'b1; in_k = 3'd2; in_tag = 4'(i);
      alpha_r = 8'(i); alpha_i = 8'(i); beta_r = 8'sd16; beta_i = 8'sd0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    checkCount++;
    if (out_valid !== 1'b0) $display("[TB] FAIL rstmid_valid got=%0b want=0", out_valid);
    else passCount++;
    checkCount++;
    if ({new_beta_r, new_beta_i, new_alpha_r, new_alpha_i, out_tag} !== 36'd0)
      $display("[TB] FAIL rstmid_outputs got=%h want=0", {new_beta_r, new_beta_i, new_alpha_r, new_alpha_i, out_tag});
    else passCount++;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checkCount++;
    if (stale !== 0) $display("[TB] FAIL rstmid_stale got=%0d want=0", stale);
    else passCount++;
  endtask

  // Run all scenarios in order and report
  initial begin
    test_reset();
    test_rotation();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
